// File: rtl/q3_test.sv
// q3_test: rear lamp controller with sequential turn signals, hazard blink, brake and fog.
// Every lamp is a register; inputs sampled at the same edge that updates the lamps.
module q3_test (
    input  logic clk,
    input  logic reset,
    input  logic left,
    input  logic right,
    input  logic brake,
    input  logic alarm,
    input  logic fog,
    output logic la,
    output logic lb,
    output logic lc,
    output logic ra,
    output logic rb,
    output logic rc
);
    logic [1:0] lph, rph, lph_n, rph_n;
    logic       blink, blink_n, hazard;
    logic [2:0] idle, lamps_l, lamps_r;

    function automatic logic [2:0] pat(input logic [1:0] p);
        return {p != 2'd0, p[1], p == 2'd3};
    endfunction

    assign hazard = alarm | (left & right);

    // Lamps show the phase being entered, so a fresh request lights 'a' at the first edge.
    always_comb begin
        lph_n   = (hazard || !left)  ? 2'd0 : lph + 2'd1;
        rph_n   = (hazard || !right) ? 2'd0 : rph + 2'd1;
        blink_n = hazard & ~blink;
        idle    = brake ? 3'b111 : fog ? 3'b001 : 3'b000;
        lamps_l = hazard ? {3{blink_n}} : left  ? pat(lph_n) : idle;
        lamps_r = hazard ? {3{blink_n}} : right ? pat(rph_n) : idle;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lph <= 2'd0;
            rph <= 2'd0;
            blink <= 1'b0;
            {la, lb, lc, ra, rb, rc} <= 6'b0;
        end else begin
            lph <= lph_n;
            rph <= rph_n;
            blink <= blink_n;
            {la, lb, lc, ra, rb, rc} <= {lamps_l, lamps_r};
        end
    end
endmodule

// File: tb/tb_q3_test.sv
// tb_q3_test: directed vectors; driver queues expected lamps, monitor checks after each edge.
module tb_q3_test;
    logic clk = 1'b0;
    logic reset, left, right, brake, alarm, fog;
    logic la, lb, lc, ra, rb, rc;
    int total = 0;
    int bad = 0;
    int n = 0;

    typedef struct {
        logic [5:0] exp;
        int         idx;
    } item_t;
    item_t q[$];

    q3_test dut (
        .clk(clk), .reset(reset), .left(left), .right(right), .brake(brake),
        .alarm(alarm), .fog(fog),
        .la(la), .lb(lb), .lc(lc), .ra(ra), .rb(rb), .rc(rc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            item_t it;
            it = q.pop_front();
            total++;
            if ({la, lb, lc, ra, rb, rc} !== it.exp) begin
                bad++;
                $display("FAIL step%0d: lamps got %b want %b", it.idx,
                         {la, lb, lc, ra, rb, rc}, it.exp);
            end
        end
    end

    // in = {reset,left,right,brake,alarm,fog}; exp = {la,lb,lc,ra,rb,rc}
    task automatic step(input logic [5:0] in, input logic [5:0] exp);
        @(negedge clk);
        {reset, left, right, brake, alarm, fog} = in;
        q.push_back('{exp, n});
        n++;
    endtask

    initial begin
        {reset, left, right, brake, alarm, fog} = 6'b100110;
        repeat (3) step(6'b100110, 6'b000000);
        step(6'b010000, 6'b100000);
        step(6'b010000, 6'b110000);
        step(6'b010000, 6'b111000);
        step(6'b010000, 6'b000000);
        step(6'b000000, 6'b000000);
        step(6'b001000, 6'b000100);
        step(6'b001000, 6'b000110);
        step(6'b001000, 6'b000111);
        step(6'b001000, 6'b000000);
        repeat (3) step(6'b000100, 6'b111111);
        step(6'b000110, 6'b111111);
        step(6'b000110, 6'b000000);
        step(6'b010010, 6'b111111);
        step(6'b010010, 6'b000000);
        step(6'b010010, 6'b111111);
        step(6'b010010, 6'b000000);
        step(6'b010000, 6'b100000);
        step(6'b000000, 6'b000000);
        step(6'b000001, 6'b001001);
        step(6'b000100, 6'b111111);
        step(6'b000000, 6'b000000);
        step(6'b010100, 6'b100111);
        step(6'b010100, 6'b110111);
        step(6'b010100, 6'b111111);
        step(6'b010100, 6'b000111);
        step(6'b011000, 6'b111111);
        step(6'b011000, 6'b000000);
        step(6'b011000, 6'b111111);
        step(6'b111000, 6'b000000);
        step(6'b010000, 6'b100000);
        step(6'b010001, 6'b110001);
        step(6'b110000, 6'b000000);
        step(6'b010000, 6'b100000);
        step(6'b000010, 6'b111111);
        step(6'b000000, 6'b000000);
        step(6'b000010, 6'b111111);
        step(6'b000000, 6'b000000);
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending got %0d want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/q3_test.md
Q3_TEST -- requirements
Module: q3_test

Interface
REQ-001 Parameters: none; fixed-function block.
REQ-002 clk  input  1  sole clock; all state changes on rising edge (nominal 1 Hz; one step per second).
REQ-003 reset  input  1  synchronous, active-high reset; one clock, sampled on rising edge of clk.
REQ-004 left  input  1  left turn-signal request, level-sensitive.
REQ-005 right  input  1  right turn-signal request, level-sensitive.
REQ-006 brake  input  1  brake pedal, level-sensitive.
REQ-007 alarm  input  1  hazard warning request, level-sensitive.
REQ-008 fog  input  1  rear fog lamp request, level-sensitive.
REQ-009 la, lb, lc  output  1 each  left lamps, inner to outer; 1 = lit.
REQ-010 ra, rb, rc  output  1 each  right lamps, inner to outer; 1 = lit.

Function
REQ-011 All six outputs SHALL be registered and updated only on rising edges of clk; inputs are sampled at the same edge, so no combinational input-to-output path exists.
REQ-012 Each side SHALL have a 2-bit turn phase: 0 = off, 1 = A, 2 = AB, 3 = ABC.
REQ-013 Phase maps to lamps: 0 -> 000, 1 -> a only, 2 -> a,b, 3 -> a,b,c.
REQ-014 Hazard mode = alarm OR (left AND right).
REQ-015 Hazard mode: a 1-bit blink flag SHALL toggle every edge; the first edge in hazard mode sets it to 1; all six outputs equal the flag.
REQ-016 Hazard mode: both turn phases SHALL be forced to 0.
REQ-017 Leaving hazard mode SHALL clear the blink flag at that edge; the normal rules then apply from that edge.
REQ-018 Outside hazard mode with left=1: left phase advances 0->1->2->3->0 each edge. Right phase behaves identically with right=1.
REQ-019 A side whose request is 0 SHALL have its phase forced to 0 at the next edge; the sequence always restarts at phase 1 when the request reasserts.
REQ-020 A side is "sequencing" when its request is 1 outside hazard mode; its lamps SHALL show the phase pattern, including the dark phase 0 step.
REQ-021 Non-sequencing side, brake=1: all three lamps of that side lit steadily.
REQ-022 Non-sequencing side, brake=0, fog=1: only the outer lamp (lc or rc) lit; a and b off.
REQ-023 Non-sequencing side, brake=0, fog=0: all three lamps of that side off.
REQ-024 Priority, highest first: reset > hazard > turn sequencing (per side) > brake > fog > off.
REQ-025 brake and fog SHALL NOT affect phase counters or the blink flag.
REQ-026 Input changes SHALL take effect at the next rising edge, with no extra pipeline delay.

Reset
REQ-027 reset=1 at an edge SHALL set la, lb, lc, ra, rb, rc = 0, both phases = 0 and blink flag = 0, regardless of all other inputs.
REQ-028 Reset SHALL take effect mid-sequence or mid-hazard; the first edge after release follows REQ-011..026 from phase 0 and flag 0.
REQ-029 Outputs SHALL hold 0 for every edge at which reset=1.

Verification
REQ-030 reset=1 for 3 edges with brake=1, alarm=1 -> all outputs 0 throughout.
REQ-031 Release reset, left=1 for 4 edges -> successive lambda (la,lb,lc) = 100, 110, 111, 000; right lamps 000; left=0 -> 000 next edge.
REQ-032 right=1 for 4 edges then brake=1 for 3 edges -> ra,rb,rc = 100,110,111,000, left 000; then all six = 1 steadily during brake.
REQ-033 alarm=1 for 6 edges, with brake or left also asserted -> all six = 1,0,1,0,1,0; alarm=0 -> normal output at next edge.
REQ-034 fog=1 alone -> lc=rc=1, others 0; then brake=1 with fog=0 -> all six 1; brake=0 -> all 0.
REQ-035 left=1 with brake=1 -> left sequences 100,110,111,000 while ra,rb,rc stay 111; left and right both 1 -> hazard blink starting at 1.
